// File: rtl/snake_pkg.sv
// Shared constants for the UART-side game status blocks: FSM encodings,
// message selects, ASCII codes and BCD digit payload.
package snake_pkg;

    localparam int unsigned INIT_DELAY_DEFAULT = 100_000;
    localparam int unsigned IDX_W              = 4;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_CONV,
        S_SEND,
        S_WAIT_HI,
        S_WAIT_LO,
        S_INCR
    } uart_state_e;

    typedef enum logic {
        MSG_SCORE,
        MSG_GO
    } msg_e;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_ZERO = 8'h30;

    typedef struct packed {
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
    } bcd3_t;

    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        return ASCII_ZERO + {4'h0, d};
    endfunction

endpackage

// File: rtl/score_reporter_if.sv
// UART transmit handshake between a byte source (master) and the uart (slave).
interface score_reporter_if;
    logic       transmit;
    logic [7:0] tx_byte;
    logic       is_transmitting;

    modport master (output transmit, output tx_byte, input is_transmitting);
    modport slave  (input transmit, input tx_byte, output is_transmitting);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one bit per cycle, BIN_W cycles after start,
// three BCD digits held until the next start.
module bin2bcd_seq
    import snake_pkg::*;
#(
    parameter int unsigned BIN_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             done_c,
    output bcd3_t            digits
);

    localparam int unsigned       CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(BIN_W - 1);

    logic             active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIN_W-1:0] sr_q, sr_d;
    bcd3_t            bcd_q, bcd_d;
    bcd3_t            adj_c;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // Add-3 correction on every digit, then shift the next binary bit in.
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        bcd_d    = bcd_q;
        adj_c    = {add3(bcd_q.d2), add3(bcd_q.d1), add3(bcd_q.d0)};
        if (start) begin
            active_d = 1'b1;
            cnt_d    = '0;
            sr_d     = bin;
            bcd_d    = '0;
        end else if (active_q) begin
            bcd_d = {adj_c[10:0], sr_q[BIN_W-1]};
            sr_d  = {sr_q[BIN_W-2:0], 1'b0};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            sr_q     <= '0;
            bcd_q    <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
            bcd_q    <= bcd_d;
        end
    end

    assign done_c = active_q && (cnt_q == LAST);
    assign digits = bcd_q;

endmodule

// File: rtl/score_reporter.sv
// Formats score and game-over events into ASCII lines and feeds them
// byte-by-byte into the shared uart transmit handshake.
module score_reporter
    import snake_pkg::*;
#(
    parameter int unsigned INIT_DELAY = INIT_DELAY_DEFAULT,
    parameter int unsigned SCORE_W    = 10,
    parameter int unsigned SCORE_MAX  = 999
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               score_valid,
    input  logic [SCORE_W-1:0] score,
    input  logic               game_over,
    score_reporter_if.master   uart,
    output logic               busy
);

    localparam int unsigned         INIT_W      = (INIT_DELAY > 1) ? $clog2(INIT_DELAY) : 1;
    localparam logic [INIT_W-1:0]  INIT_LAST   = INIT_W'(INIT_DELAY - 1);
    localparam logic [SCORE_W-1:0] SCORE_CLAMP = SCORE_W'(SCORE_MAX);
    localparam logic [IDX_W-1:0]   LAST_SCORE  = IDX_W'(6);
    localparam logic [IDX_W-1:0]   LAST_GO     = IDX_W'(10);

    uart_state_e        state_q, state_d;
    logic [INIT_W-1:0]  init_cnt_q, init_cnt_d;
    logic               score_pend_q, score_pend_d;
    logic               go_pend_q, go_pend_d;
    logic [SCORE_W-1:0] score_lat_q, score_lat_d;
    msg_e               msg_q, msg_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               transmit_q, transmit_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic               busy_q, busy_d;

    logic               score_clr_c, go_clr_c;
    logic               bcd_start_c, bcd_done_c;
    logic [SCORE_W-1:0] bcd_bin_c;
    logic [7:0]         rom_byte_c;
    bcd3_t              digits;

    assign bcd_bin_c = (score_lat_q > SCORE_CLAMP) ? SCORE_CLAMP : score_lat_q;

    bin2bcd_seq #(.BIN_W(SCORE_W)) u_bcd (
        .clk    (clk),
        .reset  (reset),
        .start  (bcd_start_c),
        .bin    (bcd_bin_c),
        .done_c (bcd_done_c),
        .digits (digits)
    );

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        msg_d       = msg_q;
        idx_d       = idx_q;
        tx_byte_d   = tx_byte_q;
        score_clr_c = 1'b0;
        go_clr_c    = 1'b0;
        bcd_start_c = 1'b0;
        rom_byte_c  = 8'h00;

        unique case (state_q)
            S_INIT: begin
                if (init_cnt_q == INIT_LAST) state_d = S_IDLE;
                else                         init_cnt_d = init_cnt_q + INIT_W'(1);
            end
            S_IDLE: begin
                if (score_pend_q) begin
                    score_clr_c = 1'b1;
                    bcd_start_c = 1'b1;
                    state_d     = S_CONV;
                end else if (go_pend_q) begin
                    go_clr_c = 1'b1;
                    msg_d    = MSG_GO;
                    idx_d    = '0;
                    state_d  = S_SEND;
                end
            end
            S_CONV: begin
                if (bcd_done_c) begin
                    msg_d   = MSG_SCORE;
                    idx_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND:    state_d = S_WAIT_HI;
            S_WAIT_HI: if (uart.is_transmitting)  state_d = S_WAIT_LO;
            S_WAIT_LO: if (!uart.is_transmitting) state_d = S_INCR;
            S_INCR: begin
                if (idx_q == ((msg_q == MSG_SCORE) ? LAST_SCORE : LAST_GO)) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_SEND;
                end
            end
            default: state_d = S_INIT;
        endcase

        // Message ROM; digits are final long before idx reaches them.
        case ({msg_d, idx_d})
            {MSG_SCORE, 4'd0}:  rom_byte_c = 8'h53;
            {MSG_SCORE, 4'd1}:  rom_byte_c = 8'h3D;
            {MSG_SCORE, 4'd2}:  rom_byte_c = digit_ascii(digits.d2);
            {MSG_SCORE, 4'd3}:  rom_byte_c = digit_ascii(digits.d1);
            {MSG_SCORE, 4'd4}:  rom_byte_c = digit_ascii(digits.d0);
            {MSG_SCORE, 4'd5}:  rom_byte_c = ASCII_CR;
            {MSG_SCORE, 4'd6}:  rom_byte_c = ASCII_LF;
            {MSG_GO,    4'd0}:  rom_byte_c = 8'h47;
            {MSG_GO,    4'd1}:  rom_byte_c = 8'h41;
            {MSG_GO,    4'd2}:  rom_byte_c = 8'h4D;
            {MSG_GO,    4'd3}:  rom_byte_c = 8'h45;
            {MSG_GO,    4'd4}:  rom_byte_c = 8'h20;
            {MSG_GO,    4'd5}:  rom_byte_c = 8'h4F;
            {MSG_GO,    4'd6}:  rom_byte_c = 8'h56;
            {MSG_GO,    4'd7}:  rom_byte_c = 8'h45;
            {MSG_GO,    4'd8}:  rom_byte_c = 8'h52;
            {MSG_GO,    4'd9}:  rom_byte_c = ASCII_CR;
            {MSG_GO,    4'd10}: rom_byte_c = ASCII_LF;
            default:            rom_byte_c = 8'h00;
        endcase

        transmit_d = (state_d == S_SEND);
        if (transmit_d) tx_byte_d = rom_byte_c;
        busy_d = (state_d != S_IDLE);

        // A new event in the same cycle as its consumption wins over the clear.
        score_pend_d = score_valid | (score_pend_q & ~score_clr_c);
        go_pend_d    = game_over   | (go_pend_q    & ~go_clr_c);
        score_lat_d  = score_valid ? score : score_lat_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_INIT;
            init_cnt_q   <= '0;
            score_pend_q <= 1'b0;
            go_pend_q    <= 1'b0;
            score_lat_q  <= '0;
            msg_q        <= MSG_SCORE;
            idx_q        <= '0;
            transmit_q   <= 1'b0;
            tx_byte_q    <= 8'h00;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            score_pend_q <= score_pend_d;
            go_pend_q    <= go_pend_d;
            score_lat_q  <= score_lat_d;
            msg_q        <= msg_d;
            idx_q        <= idx_d;
            transmit_q   <= transmit_d;
            tx_byte_q    <= tx_byte_d;
            busy_q       <= busy_d;
        end
    end

    assign uart.transmit = transmit_q;
    assign uart.tx_byte  = tx_byte_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_score_reporter.sv
// Directed bench for score_reporter: vector table of single events plus
// hand-written sequences for init hold, overwrite, handshake, latency, reset.
module tb_score_reporter;

    localparam int unsigned INIT_D = 40;
    localparam logic [7:0]  CR     = 8'h0D;
    localparam logic [7:0]  LF     = 8'h0A;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       score_valid = 1'b0;
    logic       game_over = 1'b0;
    logic [9:0] score = '0;
    logic       busy;

    score_reporter_if bus ();

    score_reporter #(
        .INIT_DELAY (INIT_D),
        .SCORE_W    (10),
        .SCORE_MAX  (999)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .score_valid (score_valid),
        .score       (score),
        .game_over   (game_over),
        .uart        (bus),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Uart model: is_transmitting rises rise_dly cycles after a pulse, holds for hold cycles.
    int rise_dly = 1;
    int hold     = 10;
    initial begin
        bus.is_transmitting = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.transmit === 1'b1) begin
                repeat (rise_dly) @(posedge clk);
                #1 bus.is_transmitting = 1'b1;
                repeat (hold) @(posedge clk);
                #1 bus.is_transmitting = 1'b0;
            end
        end
    end

    // Byte capture and protocol checks on every transmit pulse.
    logic [7:0] rx_q[$];
    int         gap_q[$];
    int         first_tx  = -1;
    int         last_fall = -1;
    logic       prev_tx   = 1'b0;
    logic       prev_istx = 1'b0;

    always @(negedge clk) begin
        if (!reset && bus.transmit === 1'b1) begin
            check("tx_back_to_back", 32'(prev_tx), 32'd0);
            check("tx_while_uart_busy", 32'(bus.is_transmitting), 32'd0);
            if (rx_q.size() == 0) first_tx = cyc;
            if (last_fall >= 0) gap_q.push_back(cyc - last_fall);
            rx_q.push_back(bus.tx_byte);
        end
        if (prev_istx && !bus.is_transmitting) last_fall = cyc;
        prev_tx   = bus.transmit;
        prev_istx = bus.is_transmitting;
    end

    task automatic clear_capture();
        rx_q.delete();
        gap_q.delete();
        first_tx  = -1;
        last_fall = -1;
    endtask

    task automatic pulse(input logic [9:0] s, input logic sv, input logic go);
        @(negedge clk);
        score       = s;
        score_valid = sv;
        game_over   = go;
        @(negedge clk);
        score_valid = 1'b0;
        game_over   = 1'b0;
    endtask

    // Idle means busy low for five consecutive cycles.
    task automatic wait_idle(input string name, input int budget);
        int quiet = 0;
        int n = 0;
        while (quiet < 5 && n < budget) begin
            @(negedge clk);
            n++;
            if (!busy) quiet++;
            else       quiet = 0;
        end
        if (quiet < 5) begin
            checks++;
            errors++;
            $display("FAIL %s_idle_timeout: busy still high after %0d cycles", name, budget);
        end
    endtask

    task automatic wait_rx(input string name, input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (rx_q.size() < n) begin
            checks++;
            errors++;
            $display("FAIL %s_rx_timeout: got %0d bytes, wanted %0d", name, rx_q.size(), n);
        end
    endtask

    task automatic check_line(input string name, input logic [143:0] exp, input int len);
        check({name, "_len"}, 32'(rx_q.size()), 32'(len));
        for (int i = 0; i < len; i++) begin
            logic [7:0] a;
            a = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            check($sformatf("%s_byte%0d", name, i), {24'h0, a}, {24'h0, exp[(len-1-i)*8 +: 8]});
        end
    endtask

    typedef struct {
        logic [9:0]   score;
        logic         do_score;
        logic         do_go;
        int           len;
        logic [143:0] exp;
    } vec_t;

    vec_t vecs[7];
    int   rel;
    int   pc;

    initial begin
        vecs[0] = '{score: 10'd42,   do_score: 1'b1, do_go: 1'b0, len: 7,  exp: 144'({"S=042", CR, LF})};
        vecs[1] = '{score: 10'd0,    do_score: 1'b1, do_go: 1'b0, len: 7,  exp: 144'({"S=000", CR, LF})};
        vecs[2] = '{score: 10'd1023, do_score: 1'b1, do_go: 1'b1, len: 18,
                    exp: 144'({"S=999", CR, LF, "GAME OVER", CR, LF})};
        vecs[3] = '{score: 10'd999,  do_score: 1'b1, do_go: 1'b0, len: 7,  exp: 144'({"S=999", CR, LF})};
        vecs[4] = '{score: 10'd1000, do_score: 1'b1, do_go: 1'b0, len: 7,  exp: 144'({"S=999", CR, LF})};
        vecs[5] = '{score: 10'd998,  do_score: 1'b1, do_go: 1'b0, len: 7,  exp: 144'({"S=998", CR, LF})};
        vecs[6] = '{score: 10'd0,    do_score: 1'b0, do_go: 1'b1, len: 11, exp: 144'({"GAME OVER", CR, LF})};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_transmit", 32'(bus.transmit), 32'd0);
        check("rst_tx_byte", 32'(bus.tx_byte), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);

        // Init hold with a slow uart
        rise_dly = 1;
        hold     = 1000;
        clear_capture();
        reset = 1'b0;
        rel   = cyc;
        repeat (10) @(negedge clk);
        score       = 10'd42;
        score_valid = 1'b1;
        @(negedge clk);
        score_valid = 1'b0;
        repeat (INIT_D - 1 - 11) @(negedge clk);
        check("init_no_tx_yet", 32'(rx_q.size()), 32'd0);
        check("init_busy", 32'(busy), 32'd1);
        wait_idle("init", 20000);
        check_line("init", 144'({"S=042", CR, LF}), 7);
        check("init_first_tx_cycle", 32'(first_tx - rel), 32'(INIT_D + 11));

        // Vector table
        hold = 10;
        for (int i = 0; i < 7; i++) begin
            clear_capture();
            pulse(vecs[i].score, vecs[i].do_score, vecs[i].do_go);
            wait_idle($sformatf("vec%0d", i), 5000);
            check_line($sformatf("vec%0d", i), vecs[i].exp, vecs[i].len);
        end

        // Overwrite: only the newest latched score is sent after the current line
        clear_capture();
        pulse(10'd300, 1'b1, 1'b0);
        wait_rx("ovw", 2, 2000);
        pulse(10'd5, 1'b1, 1'b0);
        pulse(10'd17, 1'b1, 1'b0);
        wait_idle("ovw", 5000);
        check_line("ovw", 144'({"S=300", CR, LF, "S=017", CR, LF}), 14);

        // Handshake with delayed rise and long hold
        rise_dly = 3;
        hold     = 20;
        clear_capture();
        pulse(10'd123, 1'b1, 1'b0);
        wait_idle("hs", 5000);
        check_line("hs", 144'({"S=123", CR, LF}), 7);
        check("hs_gap_count", 32'(gap_q.size()), 32'd6);
        foreach (gap_q[i]) check($sformatf("hs_gap%0d", i), 32'(gap_q[i]), 32'd2);

        // Latency from score_valid to first transmit
        rise_dly = 1;
        hold     = 10;
        clear_capture();
        @(negedge clk);
        score       = 10'd0;
        score_valid = 1'b1;
        pc          = cyc;
        @(negedge clk);
        score_valid = 1'b0;
        wait_idle("lat", 5000);
        check("lat_cycles", 32'(first_tx - pc), 32'd12);
        check_line("lat", 144'({"S=000", CR, LF}), 7);

        // Reset during the 4th byte of GAME OVER, with a score line pending
        clear_capture();
        pulse(10'd0, 1'b0, 1'b1);
        wait_rx("rst", 4, 2000);
        pulse(10'd77, 1'b1, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_transmit", 32'(bus.transmit), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        repeat (INIT_D + 40) @(negedge clk);
        check("rst_mid_no_more_bytes", 32'(rx_q.size()), 32'd4);
        check("rst_mid_byte3", {24'h0, (rx_q.size() > 3) ? rx_q[3] : 8'hxx}, 32'h45);
        check("rst_mid_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
